// File: rtl/soc_io_pkg.sv
// soc_io_pkg: shared constants and types for the Avalon I/O responder.
//   - register word addresses on the Avalon-MM slave
//   - bit position of the key event inside the EDGE register
//   - number of post-reset cycles before edge detection is trusted
//   - key debouncer state encoding
package soc_io_pkg;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_LED    = 2'd1;
  localparam logic [1:0] ADDR_EDGE   = 2'd2;
  localparam logic [1:0] ADDR_MASK   = 2'd3;

  localparam int KEY_EDGE_BIT = 8;

  // The edge detector compares the synchronizer output against its previous
  // value; both hold genuine post-reset samples only after three clocks.
  localparam logic [1:0] SETTLE_CYCLES = 2'd3;

  typedef enum logic {
    DEB_STABLE   = 1'b0,
    DEB_COUNTING = 1'b1
  } deb_state_e;

endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: accepts a new key level only after it has stayed different
// from the accepted level for DEBOUNCE_CYCLES consecutive counting cycles.
//
// Ports:
//   clk     in  system clock
//   reset   in  synchronous active-high reset (accepted level = released)
//   level   in  synchronized key level, 1 = pressed
//   pressed out debounced key level, 1 = pressed
//
// state        | meaning
// -------------+--------------------------------------------------------
// DEB_STABLE   | input matches the accepted level, counter idle
// DEB_COUNTING | input differs, counting toward acceptance
module key_debouncer
  import soc_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pressed
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  deb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pressed_q, pressed_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= DEB_STABLE;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
    end
  end

  // The counter stops at CNT_LAST, so it can never wrap.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pressed_d = pressed_q;
    case (state_q)
      DEB_STABLE: begin
        if (level != pressed_q) begin
          state_d = DEB_COUNTING;
          cnt_d   = '0;
        end
      end
      DEB_COUNTING: begin
        if (level == pressed_q) begin
          state_d = DEB_STABLE;
        end else if (cnt_q == CNT_LAST) begin
          pressed_d = level;
          state_d   = DEB_STABLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = DEB_STABLE;
    endcase
  end

  assign pressed = pressed_q;

endmodule

// File: rtl/avalon_io_responder.sv
// avalon_io_responder: Avalon-MM slave exposing switches, a push-button,
// LEDs and an edge-event interrupt.
//
// Registers: 0 STATUS (ro), 1 LED (rw), 2 EDGE (write-1-to-clear), 3 MASK (rw).
// Reads have fixed latency 1 and may issue every cycle.
//
// Ports:
//   clk               in  50 MHz system clock
//   reset             in  synchronous active-high reset
//   avs_address       in  word address
//   avs_read          in  read strobe
//   avs_write         in  write strobe
//   avs_writedata     in  write data
//   avs_readdata      out read data, zero unless avs_readdatavalid
//   avs_readdatavalid out read data qualifier
//   irq               out level interrupt, |(EDGE & MASK) registered
//   sw_in             in  asynchronous slide switches
//   key_n             in  asynchronous push-button, active-low
//   led_out           out LED drive
//
// Build option: define KEY_DEBOUNCE_EN to debounce the key through
// key_debouncer; otherwise the key is used directly after synchronization
// and DEBOUNCE_CYCLES has no effect.
module avalon_io_responder
  import soc_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic        irq,
  input  logic [7:0]  sw_in,
  input  logic        key_n,
  output logic [7:0]  led_out
);

  logic [7:0]  sw_s1, sw_s2, sw_prev;
  logic        key_s1, key_s2;
  logic        key_level, pressed, pressed_prev;
  logic [1:0]  settle_q;
  logic        armed;
  logic [8:0]  edge_q, mask_q, set_bits, clr_bits, edge_d;
  logic [7:0]  led_q;
  logic        irq_q, rdv_q;
  logic [31:0] rd_q, reg_val;
  logic        unused_wdata;

  assign key_level    = ~key_s2;
  assign unused_wdata = ^avs_writedata[31:9];

`ifdef KEY_DEBOUNCE_EN
  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clk    (clk),
    .reset  (reset),
    .level  (key_level),
    .pressed(pressed)
  );
`else
  logic unused_debounce_cycles;
  assign unused_debounce_cycles = (DEBOUNCE_CYCLES != 0);
  assign pressed = key_level;
`endif

  assign armed = (settle_q == SETTLE_CYCLES);

  always_comb begin
    set_bits = '0;
    if (armed) begin
      set_bits[7:0]          = sw_s2 ^ sw_prev;
      set_bits[KEY_EDGE_BIT] = pressed & ~pressed_prev;
    end
  end

  // Set is OR-ed in after the clear so a same-cycle event survives.
  assign clr_bits = (avs_write && avs_address == ADDR_EDGE) ? avs_writedata[8:0] : '0;
  assign edge_d   = (edge_q & ~clr_bits) | set_bits;

  always_comb begin
    reg_val = '0;
    case (avs_address)
      ADDR_STATUS: reg_val = {23'd0, pressed, sw_s2};
      ADDR_LED:    reg_val = {24'd0, led_q};
      ADDR_EDGE:   reg_val = {23'd0, edge_q};
      ADDR_MASK:   reg_val = {23'd0, mask_q};
      default:     reg_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1        <= '0;
      sw_s2        <= '0;
      sw_prev      <= '0;
      key_s1       <= 1'b1;
      key_s2       <= 1'b1;
      pressed_prev <= 1'b0;
      settle_q     <= '0;
      edge_q       <= '0;
      mask_q       <= '0;
      led_q        <= '0;
      irq_q        <= 1'b0;
      rdv_q        <= 1'b0;
      rd_q         <= '0;
    end else begin
      sw_s1        <= sw_in;
      sw_s2        <= sw_s1;
      sw_prev      <= sw_s2;
      key_s1       <= key_n;
      key_s2       <= key_s1;
      pressed_prev <= pressed;
      if (!armed) settle_q <= settle_q + 2'd1;
      edge_q       <= edge_d;
      if (avs_write && avs_address == ADDR_LED)  led_q  <= avs_writedata[7:0];
      if (avs_write && avs_address == ADDR_MASK) mask_q <= avs_writedata[8:0];
      irq_q        <= |(edge_q & mask_q);
      rdv_q        <= avs_read;
      rd_q         <= avs_read ? reg_val : '0;
    end
  end

  // Gating with reset drops a read whose response would land while reset
  // is already asserted.
  assign avs_readdatavalid = rdv_q & ~reset;
  assign avs_readdata      = avs_readdatavalid ? rd_q : '0;
  assign irq               = irq_q;
  assign led_out           = led_q;

endmodule
